hamming74_enc: RTL

HAMMING74_ENC -- requirements
Module: hamming74_enc

---
 rtl/hamming74_pkg.sv | 52 +++++
 rtl/hamming74_fifo.sv | 101 ++++++++++
 rtl/hamming74_enc.sv | 103 ++++++++++
 3 files changed

// File: rtl/hamming74_pkg.sv
// rtl/hamming74_pkg.sv - shared Hamming(7,4) constants, parity and syndrome helpers
// Purpose: widths, the parity generator used by the encoder and the
// syndrome-to-bit-position table used by the matching decoder.
// Ports: none (package).
package hamming74_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 7;

    // Marker returned by the syndrome table when no single bit is in error.
    localparam logic [2:0] POS_NONE = 3'd7;

    // p[0] covers d0,d2,d3; p[1] covers d0,d1,d2; p[2] covers d1,d2,d3.
    function automatic logic [2:0] hamming74_parity(input logic [DATA_W-1:0] d);
        logic [2:0] p;
        p[0] = d[0] ^ d[2] ^ d[3];
        p[1] = d[0] ^ d[1] ^ d[2];
        p[2] = d[1] ^ d[2] ^ d[3];
        return p;
    endfunction

    // Codeword layout: c[6:3] = data, c[2:0] = parity.
    function automatic logic [CODE_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
        return {d, hamming74_parity(d)};
    endfunction

    // Syndrome recomputed from a received codeword; zero means consistent.
    function automatic logic [2:0] hamming74_syndrome(input logic [CODE_W-1:0] c);
        logic [2:0] s;
        s[0] = c[0] ^ c[3] ^ c[5] ^ c[6];
        s[1] = c[1] ^ c[3] ^ c[4] ^ c[5];
        s[2] = c[2] ^ c[4] ^ c[5] ^ c[6];
        return s;
    endfunction

    // Syndrome -> index of the single flipped codeword bit.
    function automatic logic [2:0] hamming74_syn_to_pos(input logic [2:0] s);
        logic [2:0] pos;
        case (s)
            3'd1:    pos = 3'd0;
            3'd2:    pos = 3'd1;
            3'd3:    pos = 3'd3;
            3'd4:    pos = 3'd2;
            3'd5:    pos = 3'd6;
            3'd6:    pos = 3'd4;
            3'd7:    pos = 3'd5;
            default: pos = POS_NONE;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/hamming74_fifo.sv
// rtl/hamming74_fifo.sv - small codeword buffer with a registered head output
// Purpose: DEPTH-entry FIFO (DEPTH 2 or 4) whose head word is held in its own
// register so the output is a flop, and a word written into an empty buffer
// is visible the cycle after it is accepted.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   s_tdata/s_tvalid/s_tready   write side (s_tready low during and right after reset edge)
//   m_tdata/m_tvalid/m_tready   read side, m_tdata = head word
module hamming74_fifo
    import hamming74_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [CODE_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [CODE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CODE_W-1:0] head_q, head_d;
    logic              active_q, active_d;
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // active_q keeps s_tready low on the reset edge itself and releases it
    // on the first edge with rst_n high; ready never looks at m_tready.
    assign s_tready = active_q && (occ_q < OCC_W'(DEPTH));
    assign m_tvalid = (occ_q != '0);
    assign m_tdata  = head_q;
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        head_d   = head_q;
        active_d = 1'b1;

        if (push) begin
            mem_d[wr_ptr_q] = s_tdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // The new head is either the word being written this cycle (buffer
        // empty, or a single entry being replaced) or an already stored one.
        // An empty buffer keeps showing the last head word.
        if (occ_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = s_tdata;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            head_q   <= '0;
            active_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/hamming74_enc.sv
// rtl/hamming74_enc.sv - Hamming(7,4) encoder with output buffer and word counter
// Purpose: encodes each accepted nibble into a 7-bit codeword, buffers it in
// hamming74_fifo and counts accepted nibbles.
// Optional macro HAMMING74_ENC_ERR_INJECT_EN adds single-bit error injection.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   d, in_valid, in_ready   nibble input handshake
//   c, out_valid, out_ready codeword output handshake (c registered)
//   word_cnt                wrapping count of accepted nibbles
//   err_arm, err_pos        (macro only) arm a flip of codeword bit err_pos
module hamming74_enc
    import hamming74_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] c,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef HAMMING74_ENC_ERR_INJECT_EN
    input  logic              err_arm,
    input  logic [2:0]        err_pos,
`endif
    output logic [CNT_W-1:0]  word_cnt
);

    logic [CODE_W-1:0] code_raw;
    logic [CODE_W-1:0] code_d;
    logic              accept;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

    assign code_raw = hamming74_encode(d);
    assign accept   = in_valid && in_ready;
    assign word_cnt = word_cnt_q;

`ifdef HAMMING74_ENC_ERR_INJECT_EN
    logic              armed_q, armed_d;
    logic [CODE_W-1:0] flip_mask;

    always_comb begin
        flip_mask = '0;
        // Position 7 is outside the codeword: consumes the arm, flips nothing.
        if (armed_q && (err_pos != POS_NONE)) begin
            flip_mask[err_pos] = 1'b1;
        end
        code_d = code_raw ^ flip_mask;

        // A fresh arm on the same edge as the injected accept wins, so the
        // following nibble is corrupted as well.
        armed_d = armed_q;
        if (accept) begin
            armed_d = 1'b0;
        end
        if (err_arm) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end
`else
    assign code_d = code_raw;
`endif

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (accept) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    hamming74_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (code_d),
        .s_tvalid (in_valid),
        .s_tready (in_ready),
        .m_tdata  (c),
        .m_tvalid (out_valid),
        .m_tready (out_ready)
    );

endmodule
